alu_result_stage: RTL and testbench

Output stage of the 128-bit ALU datapath. Captures the result vector produced by the bit-sliced 8:1 operation-select mux array, together with the opsel that produced it. Derives status flags, buffers results in a small FIFO, and presents them to the consumer through a valid/ready handshake. Decouples the purely combinational ALU core from downstream back-pressure.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_result_stage_if.sv | 35 +++
 rtl/alu_flag_gen.sv | 16 +
 rtl/alu_result_stage.sv | 89 ++++++++
 tb/tb_alu_result_stage.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath types: result width, opsel codes and the buffered result record.
package alu_pkg;

    localparam int ALU_WIDTH = 128;

    typedef logic [2:0] opsel_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        opsel_t               opsel;
        logic                 zero;
        logic                 neg;
        logic                 parity;
    } alu_res_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU mux array, the result stage and the consumer.
// The stage side uses the slave modport; producer/consumer drivers use master.
interface alu_result_stage_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    opsel_t           in_opsel;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    opsel_t           out_opsel;
    logic             out_zero;
    logic             out_neg;
    logic             out_parity;
    logic [31:0]      res_count;

    modport master (
        output in_valid, in_result, in_opsel, out_ready,
        input  in_ready, out_valid, out_result, out_opsel,
               out_zero, out_neg, out_parity, res_count
    );

    modport slave (
        input  in_valid, in_result, in_opsel, out_ready,
        output in_ready, out_valid, out_result, out_opsel,
               out_zero, out_neg, out_parity, res_count
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Status flags of an ALU result: all-zero, sign (MSB) and even/odd parity.
// Purely combinational; no latency, no backpressure.
module alu_flag_gen #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             parity
);

    assign zero   = ~|result;
    assign neg    = result[WIDTH-1];
    assign parity = ^result;

endmodule

// File: rtl/alu_result_stage.sv
// ALU output stage: flags results at push time and buffers them in a DEPTH-entry FIFO.
// Latency 1 cycle push-to-out_valid; in_ready drops only when full, no empty bypass.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_stage_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    alu_res_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [31:0]   count_q;

    logic     push;
    logic     pop;
    logic     f_zero;
    logic     f_neg;
    logic     f_parity;
    alu_res_t wr_entry;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .result (bus.in_result),
        .zero   (f_zero),
        .neg    (f_neg),
        .parity (f_parity)
    );

    // Handshake outputs depend on registered occupancy only.
    assign bus.in_ready  = (occ != FULL);
    assign bus.out_valid = (occ != '0);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_entry        = '0;
        wr_entry.result = ALU_WIDTH'(bus.in_result);
        wr_entry.opsel  = bus.in_opsel;
        wr_entry.zero   = f_zero;
        wr_entry.neg    = f_neg;
        wr_entry.parity = f_parity;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (count_q != '1) begin
                    count_q <= count_q + 1'b1;
                end
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    assign bus.out_result = WIDTH'(mem[rd_ptr].result);
    assign bus.out_opsel  = mem[rd_ptr].opsel;
    assign bus.out_zero   = mem[rd_ptr].zero;
    assign bus.out_neg    = mem[rd_ptr].neg;
    assign bus.out_parity = mem[rd_ptr].parity;
    assign bus.res_count  = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage against a queue-based FIFO model.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int W = 128;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(W)) bus ();

    alu_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] r;
        logic [2:0]   op;
    } ent_t;

    ent_t        q[$];
    int unsigned exp_cnt = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_val();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected outputs come from the model queue; flags from plain arithmetic on the head.
    task automatic check_state(input string tag);
        chk({tag, ".in_ready"},  W'(bus.in_ready),  W'(q.size() < D));
        chk({tag, ".out_valid"}, W'(bus.out_valid), W'(q.size() != 0));
        chk({tag, ".res_count"}, W'(bus.res_count), W'(exp_cnt));
        if (q.size() != 0) begin
            chk({tag, ".out_result"}, bus.out_result, q[0].r);
            chk({tag, ".out_opsel"},  W'(bus.out_opsel),  W'(q[0].op));
            chk({tag, ".out_zero"},   W'(bus.out_zero),   W'(q[0].r == '0));
            chk({tag, ".out_neg"},    W'(bus.out_neg),    W'(q[0].r >= (W'(1) << (W - 1))));
            chk({tag, ".out_parity"}, W'(bus.out_parity), W'($countones(q[0].r) % 2));
        end
    endtask

    // Called at a falling edge; drives one cycle and checks after the next rising edge.
    task automatic step(input string tag, input logic v, input logic [W-1:0] r,
                        input logic [2:0] op, input logic rdy);
        bit do_push;
        bit do_pop;
        ent_t e;
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_opsel  = op;
        bus.out_ready = rdy;
        do_push = v && (q.size() < D);
        do_pop  = rdy && (q.size() != 0);
        @(posedge clk);
        if (do_pop) begin
            void'(q.pop_front());
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        end
        if (do_push) begin
            e.r  = r;
            e.op = op;
            q.push_back(e);
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle_pop(input string tag);
        step(tag, 1'b0, rnd_val(), 3'($urandom_range(0, 7)), 1'b1);
    endtask

    logic [W-1:0] v_msb;
    logic [W-1:0] v_b5;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_opsel  = 3'b000;
        bus.out_ready = 1'b0;

        // Reset values, during and after reset
        repeat (2) @(negedge clk);
        chk("rst.in_ready",   W'(bus.in_ready),   W'(1));
        chk("rst.out_valid",  W'(bus.out_valid),  W'(0));
        chk("rst.out_result", bus.out_result,     '0);
        chk("rst.out_opsel",  W'(bus.out_opsel),  W'(0));
        chk("rst.flags",      W'({bus.out_zero, bus.out_neg, bus.out_parity}), W'(0));
        chk("rst.res_count",  W'(bus.res_count),  W'(0));
        rst_n = 1'b1;
        check_state("rel");
        chk("rel.out_result", bus.out_result, '0);

        // Single push of zero, opsel 3
        step("zero_push", 1'b1, '0, 3'b011, 1'b0);
        chk("zero_push.zero_flag", W'(bus.out_zero), W'(1));
        idle_pop("zero_pop");

        // MSB + bit0, then bit5 only
        v_msb = '0;
        v_msb[W-1] = 1'b1;
        v_msb[0]   = 1'b1;
        v_b5  = '0;
        v_b5[5] = 1'b1;
        step("msb_push", 1'b1, v_msb, 3'b101, 1'b0);
        chk("msb.neg_flag", W'(bus.out_neg), W'(1));
        chk("msb.par_flag", W'(bus.out_parity), W'(0));
        step("b5_push", 1'b1, v_b5, 3'b110, 1'b1);
        chk("b5.par_flag", W'(bus.out_parity), W'(1));
        idle_pop("b5_pop");

        // Fill to full, blocked 5th push, simultaneous push+pop at full, drain
        for (int i = 0; i < D; i++) step("fill", 1'b1, rnd_val(), 3'($urandom_range(0, 7)), 1'b0);
        chk("full.in_ready", W'(bus.in_ready), W'(0));
        step("fill_blocked", 1'b1, rnd_val(), 3'b111, 1'b0);
        step("full_pushpop", 1'b1, rnd_val(), 3'b001, 1'b1);
        chk("full_pop.in_ready", W'(bus.in_ready), W'(1));
        for (int i = 0; i < D; i++) idle_pop("drain");
        chk("drain.out_valid", W'(bus.out_valid), W'(0));

        // Sustained stream of 20 with ready held high
        for (int i = 0; i < 20; i++) step("stream", 1'b1, rnd_val(), 3'($urandom_range(0, 7)), 1'b1);
        idle_pop("stream_tail");

        // Random traffic exercising pointer wrap and every occupancy
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), rnd_val(), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) != 0));

        // Reset mid-stream with entries buffered
        while (q.size() > 0) idle_pop("pre_rst_drain");
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, rnd_val(), 3'($urandom_range(0, 7)), 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        exp_cnt = 0;
        chk("midrst.out_valid", W'(bus.out_valid), W'(0));
        chk("midrst.res_count", W'(bus.res_count), W'(0));
        chk("midrst.in_ready",  W'(bus.in_ready),  W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        check_state("post_rst");
        step("post_rst_push", 1'b1, rnd_val(), 3'b010, 1'b0);
        idle_pop("post_rst_pop");
        idle_pop("post_rst_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
